// File: rtl/dma_channel_requester.sv
// Per-channel DMA requester: splits a transfer into bursts and requests the shared engine for each.
// Optional DMA_CH_4K_SPLIT_EN keeps every burst inside a 4 KB page for both source and destination.
module dma_channel_requester #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic                  cfg_abort,
  input  logic [ADDR_WIDTH-1:0] cfg_src,
  input  logic [ADDR_WIDTH-1:0] cfg_dst,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [1:0]            cfg_priority,
  output logic                  channel_request,
  output logic [1:0]            channel_priority,
  input  logic                  channel_grant,
  output logic                  eng_start,
  output logic [ADDR_WIDTH-1:0] eng_src,
  output logic [ADDR_WIDTH-1:0] eng_dst,
  output logic [7:0]            eng_beats,
  input  logic                  engine_done,
  input  logic                  engine_error,
  output logic                  busy,
  output logic [LEN_WIDTH-1:0]  remaining,
  output logic                  done_irq,
  output logic                  error_irq
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ISSUE, S_WAIT, S_FIN} state_t;

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] src, dst;
  logic                  abort_pend;
  logic                  done_nx, err_nx;
  logic [LEN_WIDTH-1:0]  rem_after;
  logic [31:0]           rem_ext, lim, burst;

  assign rem_after = remaining - LEN_WIDTH'(eng_beats);

  // Beat count for the next burst, sized wide enough for the 1024-word page limit.
  always_comb begin
    rem_ext = 32'(remaining);
    lim     = 32'(MAX_BURST);
`ifdef DMA_CH_4K_SPLIT_EN
    if (32'd1024 - 32'(src[11:2]) < lim) lim = 32'd1024 - 32'(src[11:2]);
    if (32'd1024 - 32'(dst[11:2]) < lim) lim = 32'd1024 - 32'(dst[11:2]);
`endif
    burst = (rem_ext < lim) ? rem_ext : lim;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    case (state)
      S_IDLE: begin
        if (cfg_start) begin
          if (cfg_len != '0) state_nx = S_REQ;
          else               done_nx  = 1'b1;
        end
      end
      S_REQ: begin
        if (cfg_abort) begin
          state_nx = S_IDLE;
          err_nx   = 1'b1;
        end else if (channel_grant) begin
          state_nx = S_ISSUE;
        end
      end
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT: begin
        // Error wins over done; a pending abort turns a done into an error exit.
        if (engine_error || (engine_done && (abort_pend || cfg_abort))) begin
          state_nx = S_IDLE;
          err_nx   = 1'b1;
        end else if (engine_done) begin
          state_nx = (rem_after == '0) ? S_FIN : S_REQ;
        end
      end
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src              <= '0;
      dst              <= '0;
      abort_pend       <= 1'b0;
      channel_request  <= 1'b0;
      channel_priority <= 2'd0;
      eng_start        <= 1'b0;
      eng_src          <= '0;
      eng_dst          <= '0;
      eng_beats        <= 8'd0;
      busy             <= 1'b0;
      remaining        <= '0;
      done_irq         <= 1'b0;
      error_irq        <= 1'b0;
    end else begin
      channel_request <= (state_nx == S_REQ);
      eng_start       <= (state_nx == S_ISSUE);
      busy            <= (state_nx != S_IDLE);
      done_irq        <= done_nx || (state_nx == S_FIN);
      error_irq       <= err_nx;

      if (state == S_IDLE && cfg_start && cfg_len != '0) begin
        src              <= {cfg_src[ADDR_WIDTH-1:2], 2'b00};
        dst              <= {cfg_dst[ADDR_WIDTH-1:2], 2'b00};
        remaining        <= cfg_len;
        channel_priority <= cfg_priority;
      end
      if (state == S_REQ && state_nx == S_ISSUE) begin
        eng_src   <= src;
        eng_dst   <= dst;
        eng_beats <= burst[7:0];
      end
      if (state == S_WAIT && engine_done && !engine_error) begin
        src       <= src + (ADDR_WIDTH'(eng_beats) << 2);
        dst       <= dst + (ADDR_WIDTH'(eng_beats) << 2);
        remaining <= rem_after;
      end
      if ((state == S_ISSUE || state == S_WAIT) && cfg_abort) abort_pend <= 1'b1;
      if (state_nx == S_IDLE) abort_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dma_channel_requester.sv
// Directed self-checking bench for dma_channel_requester (default parameters).
module tb_dma_channel_requester;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cfg_start = 1'b0, cfg_abort = 1'b0;
  logic [31:0] cfg_src = '0, cfg_dst = '0;
  logic [15:0] cfg_len = '0;
  logic [1:0]  cfg_priority = '0;
  logic        channel_request, channel_grant = 1'b0;
  logic [1:0]  channel_priority;
  logic        eng_start;
  logic [31:0] eng_src, eng_dst;
  logic [7:0]  eng_beats;
  logic        engine_done = 1'b0, engine_error = 1'b0;
  logic        busy, done_irq, error_irq;
  logic [15:0] remaining;

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;

  dma_channel_requester dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len), .cfg_priority(cfg_priority),
    .channel_request(channel_request), .channel_priority(channel_priority),
    .channel_grant(channel_grant),
    .eng_start(eng_start), .eng_src(eng_src), .eng_dst(eng_dst), .eng_beats(eng_beats),
    .engine_done(engine_done), .engine_error(engine_error),
    .busy(busy), .remaining(remaining), .done_irq(done_irq), .error_irq(error_irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (eng_start) start_cnt <= start_cnt + 1;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    cfg_src = s; cfg_dst = d; cfg_len = n; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  // Acts as arbiter and engine for one burst; ev 0=done, 1=error, 2=both.
  task automatic serve_burst(input bit held, input int ev, output logic [7:0] beats,
                             output logic [31:0] bsrc, output logic [31:0] bdst,
                             output logic started);
    int n = 0;
    while (!channel_request && n < 20) begin tick(); n++; end
    if (!channel_request) begin
      errors++; checks++;
      $display("FAIL req_timeout: channel_request=%0b required 1", channel_request);
    end
    channel_grant = 1'b1;
    tick();
    started = eng_start; beats = eng_beats; bsrc = eng_src; bdst = eng_dst;
    if (!held) channel_grant = 1'b0;
    tick(); tick();
    engine_done = (ev != 1); engine_error = (ev != 0);
    tick();
    engine_done = 1'b0; engine_error = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    tick(); tick();
    checks++;
    if ({channel_request, eng_start, busy, done_irq, error_irq} !== 5'b0 || remaining !== 16'd0 ||
        eng_beats !== 8'd0 || channel_priority !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: req=%0b start=%0b busy=%0b done=%0b err=%0b rem=%0d required all 0",
               channel_request, eng_start, busy, done_irq, error_irq, remaining);
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    checks++;
    if (error_irq !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: error_irq=%0b busy=%0b required 0 0", error_irq, busy);
    end
  endtask

  task automatic test_basic();
    logic [7:0]  exp_beats [3] = '{8'd16, 8'd16, 8'd8};
    logic [31:0] exp_src   [3] = '{32'h1000, 32'h1040, 32'h1080};
    logic [7:0]  b;
    logic [31:0] s, d;
    logic        st;
    int          c0 = start_cnt;
    cfg_priority = 2'd2;
    start_xfer(32'h1003, 32'h2000, 16'd40);
    checks++;
    if (channel_request !== 1'b1 || busy !== 1'b1 || channel_priority !== 2'd2) begin
      errors++;
      $display("FAIL basic_req_rise: req=%0b busy=%0b prio=%0d required 1 1 2",
               channel_request, busy, channel_priority);
    end
    for (int i = 0; i < 3; i++) begin
      serve_burst(1'b0, 0, b, s, d, st);
      checks++;
      if (st !== 1'b1 || b !== exp_beats[i] || s !== exp_src[i] || d !== exp_src[i] + 32'h1000) begin
        errors++;
        $display("FAIL basic_burst%0d: start=%0b beats=%0d src=%h dst=%h required 1 %0d %h %h",
                 i, st, b, s, d, exp_beats[i], exp_src[i], exp_src[i] + 32'h1000);
      end
      if (i < 2) begin
        checks++;
        if (channel_request !== 1'b1) begin
          errors++;
          $display("FAIL basic_rereq%0d: channel_request=%0b required 1", i, channel_request);
        end
      end
    end
    checks++;
    if (done_irq !== 1'b1 || error_irq !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_irq: done_irq=%0b error_irq=%0b required 1 0", done_irq, error_irq);
    end
    tick();
    checks++;
    if (done_irq !== 1'b0 || busy !== 1'b0 || remaining !== 16'd0 || start_cnt - c0 != 3) begin
      errors++;
      $display("FAIL basic_end: done=%0b busy=%0b rem=%0d starts=%0d required 0 0 0 3",
               done_irq, busy, remaining, start_cnt - c0);
    end
  endtask

  task automatic test_zero_len();
    int c0 = start_cnt;
    start_xfer(32'h4000, 32'h5000, 16'd0);
    checks++;
    if (done_irq !== 1'b1 || channel_request !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_irq: done=%0b req=%0b busy=%0b required 1 0 0",
               done_irq, channel_request, busy);
    end
    tick(); tick();
    checks++;
    if (done_irq !== 1'b0 || channel_request !== 1'b0 || start_cnt != c0) begin
      errors++;
      $display("FAIL zero_len_after: done=%0b req=%0b starts=%0d required 0 0 0",
               done_irq, channel_request, start_cnt - c0);
    end
  endtask

  task automatic test_error();
    logic [7:0]  b;
    logic [31:0] s, d;
    logic        st;
    start_xfer(32'h1000, 32'h2000, 16'd40);
    serve_burst(1'b0, 0, b, s, d, st);
    serve_burst(1'b0, 1, b, s, d, st);
    checks++;
    if (error_irq !== 1'b1 || busy !== 1'b0 || remaining !== 16'd24 || done_irq !== 1'b0) begin
      errors++;
      $display("FAIL error_exit: err=%0b busy=%0b rem=%0d done=%0b required 1 0 24 0",
               error_irq, busy, remaining, done_irq);
    end
    tick(); tick(); tick();
    checks++;
    if (error_irq !== 1'b0 || channel_request !== 1'b0) begin
      errors++;
      $display("FAIL error_quiet: err=%0b req=%0b required 0 0", error_irq, channel_request);
    end
  endtask

  task automatic test_abort();
    start_xfer(32'h1000, 32'h2000, 16'd40);
    channel_grant = 1'b1;
    tick();
    channel_grant = 1'b0;
    tick();
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    checks++;
    if (error_irq !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_wait_hold: err=%0b busy=%0b required 0 1", error_irq, busy);
    end
    engine_done = 1'b1;
    tick();
    engine_done = 1'b0;
    checks++;
    if (error_irq !== 1'b1 || busy !== 1'b0 || channel_request !== 1'b0 || done_irq !== 1'b0) begin
      errors++;
      $display("FAIL abort_wait_exit: err=%0b busy=%0b req=%0b done=%0b required 1 0 0 0",
               error_irq, busy, channel_request, done_irq);
    end
    tick(); tick();
    checks++;
    if (channel_request !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_wait_norereq: req=%0b busy=%0b required 0 0", channel_request, busy);
    end
    start_xfer(32'h1000, 32'h2000, 16'd8);
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    checks++;
    if (error_irq !== 1'b1 || busy !== 1'b0 || channel_request !== 1'b0) begin
      errors++;
      $display("FAIL abort_req: err=%0b busy=%0b req=%0b required 1 0 0",
               error_irq, busy, channel_request);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  b0, b1;
    logic [31:0] s, d;
    logic        st;
    int          c0 = start_cnt;
    start_xfer(32'h0, 32'h800, 16'd20);
    serve_burst(1'b1, 0, b0, s, d, st);
    serve_burst(1'b1, 0, b1, s, d, st);
    checks++;
    if (done_irq !== 1'b1 || b0 !== 8'd16 || b1 !== 8'd4) begin
      errors++;
      $display("FAIL held_grant_bursts: done=%0b beats=%0d/%0d required 1 16/4", done_irq, b0, b1);
    end
    channel_grant = 1'b0;
    tick(); tick();
    checks++;
    if (start_cnt - c0 != 2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL held_grant_starts: starts=%0d busy=%0b required 2 0", start_cnt - c0, busy);
    end
    start_xfer(32'h1000, 32'h2000, 16'd40);
    serve_burst(1'b0, 2, b0, s, d, st);
    checks++;
    if (error_irq !== 1'b1 || done_irq !== 1'b0 || busy !== 1'b0 || remaining !== 16'd40) begin
      errors++;
      $display("FAIL done_and_error: err=%0b done=%0b busy=%0b rem=%0d required 1 0 0 40",
               error_irq, done_irq, busy, remaining);
    end
    tick();
  endtask

  task automatic test_4k_split();
    logic [7:0]  b0, b1;
    logic [31:0] s0, s1, d;
    logic        st;
    start_xfer(32'h1FF0, 32'h3000, 16'd16);
    serve_burst(1'b0, 0, b0, s0, d, st);
`ifdef DMA_CH_4K_SPLIT_EN
    serve_burst(1'b0, 0, b1, s1, d, st);
    checks++;
    if (b0 !== 8'd4 || b1 !== 8'd12 || s0 !== 32'h1FF0 || s1 !== 32'h2000 || done_irq !== 1'b1) begin
      errors++;
      $display("FAIL split_4k: beats=%0d/%0d src=%h/%h done=%0b required 4/12 1ff0/2000 1",
               b0, b1, s0, s1, done_irq);
    end
`else
    b1 = 8'd0; s1 = '0;
    checks++;
    if (b0 !== 8'd16 || s0 !== 32'h1FF0 || done_irq !== 1'b1) begin
      errors++;
      $display("FAIL no_split_4k: beats=%0d src=%h done=%0b required 16 1ff0 1", b0, s0, done_irq);
    end
`endif
    tick();
  endtask

  task automatic test_reset_mid();
    start_xfer(32'h1000, 32'h2000, 16'd40);
    channel_grant = 1'b1;
    tick();
    channel_grant = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({channel_request, eng_start, busy, done_irq, error_irq} !== 5'b0 || remaining !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid: req=%0b start=%0b busy=%0b done=%0b err=%0b rem=%0d required all 0",
               channel_request, eng_start, busy, done_irq, error_irq, remaining);
    end
    @(negedge clk) rst_n = 1'b1;
    tick(); tick();
    checks++;
    if (busy !== 1'b0 || error_irq !== 1'b0 || done_irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after: busy=%0b err=%0b done=%0b required 0 0 0",
               busy, error_irq, done_irq);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_error();
    test_abort();
    test_back_to_back();
    test_4k_split();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
